algo_4r4w1p_p603_init_seq: RTL and testbench

Memory initialization sequencer between the 4r4w1p_p603 algorithmic core and its t1 physical banks. After reset, or on request, it owns the t1 ports and writes `INITVAL` to every physical row of every group and bank. It then hands the ports to the core and qualifies the core's `ready`. While sweeping, all core-side t1 traffic is suppressed.

---
 rtl/algo_4r4w1p_p603_init_seq.sv | 123 ++++++++++++
 tb/tb_algo_4r4w1p_p603_init_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/algo_4r4w1p_p603_init_seq.sv
// Initialization sequencer for the 4r4w1p_p603 t1 banks: sweeps INITVAL into every
// physical row, drains, then hands the t1 ports to the algorithmic core.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | one cycle after reset, t1 ports quiet
// S_INIT  | sweep: write INITVAL to row `row` in every group, one row per cycle
// S_DRAIN | SRAM_DELAY quiet cycles so the last init write settles
// S_RUN   | core owns the t1 ports, ready qualified by core_ready
module algo_4r4w1p_p603_init_seq #(
  parameter int NUMVBNK    = 1,
  parameter int NUMGRPW    = 13,
  parameter int BITVROW    = 13,
  parameter int NUMSROW    = 4096,
  parameter int BITSROW    = 12,
  parameter int PHYWDTH    = 128,
  parameter int SRAM_DELAY = 1,
  parameter logic [PHYWDTH-1:0] INITVAL = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 init_req,
  input  logic                                 core_ready,
  input  logic [NUMGRPW*NUMVBNK-1:0]           core_writeA,
  input  logic [NUMGRPW*NUMVBNK*BITVROW-1:0]   core_addrA,
  input  logic [NUMVBNK*PHYWDTH-1:0]           core_dinA,
  input  logic [NUMVBNK*PHYWDTH-1:0]           core_bwA,
  input  logic [NUMGRPW*NUMVBNK-1:0]           core_readB,
  input  logic [NUMGRPW*NUMVBNK*BITSROW-1:0]   core_addrB,
  output logic [NUMVBNK*PHYWDTH-1:0]           core_doutB,
  output logic [NUMGRPW*NUMVBNK-1:0]           t1_writeA,
  output logic [NUMGRPW*NUMVBNK*BITVROW-1:0]   t1_addrA,
  output logic [NUMVBNK*PHYWDTH-1:0]           t1_dinA,
  output logic [NUMVBNK*PHYWDTH-1:0]           t1_bwA,
  output logic [NUMGRPW*NUMVBNK-1:0]           t1_readB,
  output logic [NUMGRPW*NUMVBNK*BITSROW-1:0]   t1_addrB,
  input  logic [NUMVBNK*PHYWDTH-1:0]           t1_doutB,
  output logic                                 ready,
  output logic                                 init_busy
);

  localparam int NW  = NUMGRPW * NUMVBNK;
  localparam int DCW = (SRAM_DELAY < 1) ? 1 : $clog2(SRAM_DELAY + 1);
  localparam logic [BITSROW-1:0] ROW_LAST  = BITSROW'(NUMSROW - 1);
  localparam logic [DCW-1:0]     DCNT_LAST = (SRAM_DELAY == 0) ? '0 : DCW'(SRAM_DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAIN, S_RUN} state_t;

  state_t             state;
  logic [BITSROW-1:0] row;
  logic [DCW-1:0]     dcnt;
  logic [BITVROW-1:0] row_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      row   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_INIT;
          row   <= '0;
        end
        S_INIT: begin
          if (row == ROW_LAST) begin
            row   <= '0;
            dcnt  <= '0;
            state <= (SRAM_DELAY == 0) ? S_RUN : S_DRAIN;
          end else begin
            row <= row + 1'b1;
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == DCNT_LAST) state <= S_RUN;
        end
        S_RUN: begin
          // init_req is only honoured here; in the other states it is simply dropped
          if (init_req) begin
            state <= S_INIT;
            row   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign row_ext = BITVROW'(row);

  // Port ownership decodes from the registered state only, so init_req never reaches an output
  always_comb begin
    t1_writeA = '0;
    t1_addrA  = '0;
    t1_dinA   = '0;
    t1_bwA    = '0;
    t1_readB  = '0;
    t1_addrB  = '0;
    case (state)
      S_INIT: begin
        t1_writeA = '1;
        t1_addrA  = {NW{row_ext}};
        t1_dinA   = {NUMVBNK{INITVAL}};
        t1_bwA    = '1;
      end
      S_RUN: begin
        t1_writeA = core_writeA;
        t1_addrA  = core_addrA;
        t1_dinA   = core_dinA;
        t1_bwA    = core_bwA;
        t1_readB  = core_readB;
        t1_addrB  = core_addrB;
      end
      default: ;
    endcase
  end

  assign core_doutB = t1_doutB;
  assign ready      = (state == S_RUN) & core_ready;
  assign init_busy  = (state == S_INIT) | (state == S_DRAIN);

endmodule

// File: tb/tb_algo_4r4w1p_p603_init_seq.sv
// Bench for the init sequencer: cycle-count model of the sweep plus a small t1 SRAM,
// compared every cycle, with directed sweep/passthrough/re-init/reset scenarios.
module tb_algo_4r4w1p_p603_init_seq;

  localparam int NV = 1;
  localparam int NG = 13;
  localparam int BV = 13;
  localparam int NS = 8;
  localparam int BS = 3;
  localparam int PW = 128;
  localparam int SD = 1;
  localparam int NW = NG * NV;
  localparam logic [PW-1:0] IV = {16{8'hA5}};

  logic                 clk;
  logic                 rst = 1'b0;
  logic                 init_req;
  logic                 core_ready;
  logic [NW-1:0]        core_writeA;
  logic [NW*BV-1:0]     core_addrA;
  logic [NV*PW-1:0]     core_dinA;
  logic [NV*PW-1:0]     core_bwA;
  logic [NW-1:0]        core_readB;
  logic [NW*BS-1:0]     core_addrB;
  logic [NV*PW-1:0]     core_doutB;
  logic [NW-1:0]        t1_writeA;
  logic [NW*BV-1:0]     t1_addrA;
  logic [NV*PW-1:0]     t1_dinA;
  logic [NV*PW-1:0]     t1_bwA;
  logic [NW-1:0]        t1_readB;
  logic [NW*BS-1:0]     t1_addrB;
  logic [NV*PW-1:0]     t1_doutB;
  logic                 ready;
  logic                 init_busy;

  int checks = 0;
  int errors = 0;

  algo_4r4w1p_p603_init_seq #(
    .NUMVBNK(NV), .NUMGRPW(NG), .BITVROW(BV), .NUMSROW(NS), .BITSROW(BS),
    .PHYWDTH(PW), .SRAM_DELAY(SD), .INITVAL(IV)
  ) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .core_ready(core_ready),
    .core_writeA(core_writeA), .core_addrA(core_addrA), .core_dinA(core_dinA),
    .core_bwA(core_bwA), .core_readB(core_readB), .core_addrB(core_addrB),
    .core_doutB(core_doutB), .t1_writeA(t1_writeA), .t1_addrA(t1_addrA),
    .t1_dinA(t1_dinA), .t1_bwA(t1_bwA), .t1_readB(t1_readB), .t1_addrB(t1_addrB),
    .t1_doutB(t1_doutB), .ready(ready), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NW*BV-1:0] rep_row(input int r);
    logic [NW*BV-1:0] v;
    for (int g = 0; g < NW; g++) v[g*BV +: BV] = BV'(r);
    return v;
  endfunction

  // t1 SRAM: bit-masked writes, one-cycle registered read
  logic [PW-1:0] mem [NS];
  initial begin
    for (int i = 0; i < NS; i++) mem[i] = '0;
    t1_doutB = '0;
  end
  always @(posedge clk) begin
    for (int g = 0; g < NW; g++) begin
      if (t1_writeA[g])
        mem[t1_addrA[g*BV +: BS]] <= (mem[t1_addrA[g*BV +: BS]] & ~t1_bwA) | (t1_dinA & t1_bwA);
      if (t1_readB[g]) t1_doutB <= mem[t1_addrB[g*BS +: BS]];
    end
  end

  // mk = cycles since the sweep began: 0 idle, 1..NS init rows, then drain, then run
  int mk = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) mk <= 0;
    else if (mk >= NS + SD + 1) begin
      if (init_req) mk <= 1;
    end else mk <= mk + 1;
  end

  logic             e_ini, e_run;
  logic [NW-1:0]    e_wa, e_rb;
  logic [NW*BV-1:0] e_aa;
  logic [NW*BS-1:0] e_ab;
  logic [PW-1:0]    e_din, e_bw;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      e_ini = (mk >= 1) && (mk <= NS);
      e_run = (mk >= NS + SD + 1);
      e_wa  = e_ini ? '1 : (e_run ? core_writeA : '0);
      e_aa  = e_ini ? rep_row(mk - 1) : (e_run ? core_addrA : '0);
      e_din = e_ini ? IV : (e_run ? core_dinA : '0);
      e_bw  = e_ini ? '1 : (e_run ? core_bwA : '0);
      e_rb  = e_run ? core_readB : '0;
      e_ab  = e_run ? core_addrB : '0;
      chk("m_writeA", 256'(t1_writeA), 256'(e_wa));
      chk("m_addrA",  256'(t1_addrA),  256'(e_aa));
      chk("m_dinA",   256'(t1_dinA),   256'(e_din));
      chk("m_bwA",    256'(t1_bwA),    256'(e_bw));
      chk("m_readB",  256'(t1_readB),  256'(e_rb));
      chk("m_addrB",  256'(t1_addrB),  256'(e_ab));
      chk("m_ready",  256'(ready),     256'(e_run & core_ready));
      chk("m_busy",   256'(init_busy), 256'((mk >= 1) && (mk <= NS + SD)));
      chk("m_doutB",  256'(core_doutB), 256'(t1_doutB));
    end
  end

  // Cycle 0 is the IDLE cycle right after release; core junk (bw=0) is presented during the sweep
  task automatic sweep_check();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        core_writeA = '1; core_addrA = '1; core_dinA = '1; core_bwA = '0;
        core_readB = '1; core_addrB = '1;
      end
      if (c == 9) begin
        core_writeA = '0; core_addrA = '0; core_dinA = '0;
        core_readB = '0; core_addrB = '0;
      end
      #1;
      case (c)
        0: chk("idle_writeA", 256'(t1_writeA), 256'(0));
        1: begin
          chk("init0_writeA", 256'(t1_writeA), 256'(13'h1FFF));
          chk("init0_addr",   256'(t1_addrA[0 +: BV]), 256'(0));
        end
        5: begin
          chk("init4_addr", 256'(t1_addrA[12*BV +: BV]), 256'(4));
          chk("init4_din",  256'(t1_dinA), 256'(IV));
        end
        8: chk("init7_addr", 256'(t1_addrA[0 +: BV]), 256'(7));
        9: begin
          chk("drain_busy",   256'(init_busy), 256'(1));
          chk("drain_writeA", 256'(t1_writeA), 256'(0));
          chk("drain_ready",  256'(ready), 256'(0));
        end
        10: begin
          chk("run_ready", 256'(ready), 256'(1));
          chk("run_busy",  256'(init_busy), 256'(0));
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    init_req = 0; core_ready = 1;
    core_writeA = '0; core_addrA = '0; core_dinA = '0; core_bwA = '0;
    core_readB = '0; core_addrB = '0;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",  256'(ready), 256'(0));
    chk("rst_busy",   256'(init_busy), 256'(0));
    chk("rst_writeA", 256'(t1_writeA), 256'(0));
    chk("rst_readB",  256'(t1_readB), 256'(0));

    @(negedge clk);
    rst = 0;
    sweep_check();

    for (int r = 0; r <= NS; r++) begin
      @(negedge clk);
      if (r < NS) begin
        core_readB = NW'(1);
        core_addrB[0 +: BS] = BS'(r);
      end else core_readB = '0;
      #1;
      if (r > 0) chk("rd_init", 256'(core_doutB), 256'(IV));
    end

    @(negedge clk);
    core_writeA = NW'(8); core_addrA[3*BV +: BV] = BV'(5);
    core_dinA = 128'h1234; core_bwA = '1;
    #1;
    chk("pt_writeA", 256'(t1_writeA), 256'(8));
    chk("pt_addrA",  256'(t1_addrA[3*BV +: BV]), 256'(5));
    chk("pt_dinA",   256'(t1_dinA), 256'(128'h1234));
    @(negedge clk);
    core_writeA = '0; core_readB = NW'(1); core_addrB[0 +: BS] = 3'd5;
    @(negedge clk);
    core_readB = '0;
    #1 chk("rd_core_wr", 256'(core_doutB), 256'(128'h1234));
    core_ready = 0;
    #1 chk("ready_off", 256'(ready), 256'(0));
    @(negedge clk);
    core_ready = 1;
    #1 chk("ready_on", 256'(ready), 256'(1));

    // re-init at cycle N with a core write in the same cycle; second request at N+3 is ignored
    @(negedge clk);
    init_req = 1; core_writeA = NW'(1); core_addrA = '0; core_addrA[0 +: BV] = BV'(2);
    core_dinA = 128'hBEEF;
    #1;
    chk("req_pass", 256'(t1_writeA), 256'(1));
    chk("req_ready", 256'(ready), 256'(1));
    for (int d = 1; d <= 10; d++) begin
      @(negedge clk);
      if (d == 1) begin init_req = 0; core_writeA = '0; core_addrA = '0; core_dinA = '0; end
      if (d == 3) init_req = 1;
      if (d == 4) init_req = 0;
      #1;
      case (d)
        1: begin
          chk("reinit_ready", 256'(ready), 256'(0));
          chk("reinit_busy",  256'(init_busy), 256'(1));
        end
        4: chk("no_restart_row3", 256'(t1_addrA[0 +: BV]), 256'(3));
        8: chk("reinit_last_row", 256'(t1_addrA[0 +: BV]), 256'(7));
        9: chk("reinit_drain_ready", 256'(ready), 256'(0));
        10: chk("reinit_run_ready", 256'(ready), 256'(1));
        default: ;
      endcase
    end
    @(negedge clk);
    core_readB = NW'(1); core_addrB[0 +: BS] = 3'd2;
    @(negedge clk);
    core_readB = NW'(1); core_addrB[0 +: BS] = 3'd5;
    #1 chk("rd_row2_reinit", 256'(core_doutB), 256'(IV));
    @(negedge clk);
    core_readB = '0;
    #1 chk("rd_row5_reinit", 256'(core_doutB), 256'(IV));

    // reset in the middle of the sweep at row 4
    @(negedge clk);
    init_req = 1;
    @(negedge clk);
    init_req = 0;
    repeat (4) @(negedge clk);
    #1 chk("pre_rst_row4", 256'(t1_addrA[0 +: BV]), 256'(4));
    #2 rst = 1;
    #1;
    chk("midrst_writeA", 256'(t1_writeA), 256'(0));
    chk("midrst_busy",   256'(init_busy), 256'(0));
    @(negedge clk);
    rst = 0;
    sweep_check();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
